// File: rtl/apb_to_ahbl_pkg.sv
// rtl/apb_to_ahbl_pkg.sv - busfabric AHB-Lite encodings shared by the AHB blocks
package apb_to_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // HSIZE encoding for a full-width beat of the given data bus width
    function automatic logic [2:0] hsize_for(input int w_data);
        return 3'($clog2(w_data / 8));
    endfunction

endpackage

// File: rtl/apb_to_ahbl.sv
// rtl/apb_to_ahbl.sv - APB responder to AHB-Lite initiator bridge, one single beat per APB transfer
module apb_to_ahbl
    import apb_to_ahbl_pkg::*;
#(
    parameter int                 W_PADDR    = 16,
    parameter int                 W_HADDR    = 32,
    parameter int                 W_DATA     = 32,
    parameter logic [W_HADDR-1:0] HADDR_BASE = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               apbs_psel,
    input  logic               apbs_penable,
    input  logic               apbs_pwrite,
    input  logic [W_PADDR-1:0] apbs_paddr,
    input  logic [W_DATA-1:0]  apbs_pwdata,
    output logic               apbs_pready,
    output logic [W_DATA-1:0]  apbs_prdata,
    output logic               apbs_pslverr,
    input  logic               ahblm_hready,
    input  logic               ahblm_hresp,
    output logic [W_HADDR-1:0] ahblm_haddr,
    output logic               ahblm_hwrite,
    output logic [1:0]         ahblm_htrans,
    output logic [2:0]         ahblm_hsize,
    output logic [2:0]         ahblm_hburst,
    output logic [3:0]         ahblm_hprot,
    output logic               ahblm_hmastlock,
    output logic [W_DATA-1:0]  ahblm_hwdata,
    input  logic [W_DATA-1:0]  ahblm_hrdata
);

    localparam int                 W_LSB    = $clog2(W_DATA / 8);
    localparam logic [W_HADDR-1:0] LSB_MASK = W_HADDR'((1 << W_LSB) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [W_HADDR-1:0]  r_haddr;
    logic                r_hwrite;
    logic [W_DATA-1:0]   r_hwdata;
    logic [W_DATA-1:0]   r_prdata;
    logic                r_pslverr;
    logic                w_setup;
    logic [W_HADDR-1:0]  w_haddr_setup;

    // Only a setup phase starts a transfer; an access phase alone is never treated as new work
    assign w_setup       = apbs_psel && !apbs_penable;
    // Upper address bits come from the fabric window, lower from APB, aligned to a full-width beat
    assign w_haddr_setup = {HADDR_BASE[W_HADDR-1:W_PADDR], apbs_paddr} & ~LSB_MASK;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: setup -> address phase -> data phase -> one-cycle APB completion
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_setup)      w_state_next = S_ADDR;
            S_ADDR:  if (ahblm_hready) w_state_next = S_DATA;
            S_DATA:  if (ahblm_hready) w_state_next = S_RESP;
            S_RESP:                    w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    // Capture the request at APB setup and the response at the end of the AHB data phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_haddr   <= '0;
            r_hwrite  <= 1'b0;
            r_hwdata  <= '0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_setup) begin
                r_haddr  <= w_haddr_setup;
                r_hwrite <= apbs_pwrite;
                if (apbs_pwrite) begin
                    r_hwdata <= apbs_pwdata;
                end
            end
            // The first ERROR cycle has hready low, so only the final cycle reaches here
            if (r_state == S_DATA && ahblm_hready) begin
                r_pslverr <= (ahblm_hresp != HRESP_OKAY);
                r_prdata  <= r_hwrite ? '0 : ahblm_hrdata;
            end
        end
    end

    assign apbs_pready     = (r_state == S_RESP);
    assign apbs_prdata     = r_prdata;
    assign apbs_pslverr    = r_pslverr;
    assign ahblm_haddr     = r_haddr;
    assign ahblm_hwrite    = r_hwrite;
    assign ahblm_hwdata    = r_hwdata;
    assign ahblm_htrans    = (r_state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahblm_hsize     = hsize_for(W_DATA);
    assign ahblm_hburst    = HBURST_SINGLE;
    assign ahblm_hprot     = HPROT_DEFAULT;
    assign ahblm_hmastlock = 1'b0;

endmodule

// File: doc/apb_to_ahbl.md
Name: apb_to_ahbl

Overview:
APB responder to AHB-Lite initiator bridge. Lets an APB-attached agent (debug/config master on the peripheral bus) reach the AHB-Lite fabric. Each APB transfer becomes exactly one single-beat, full-width AHB-Lite transfer. The APB access phase is stalled until the AHB data phase completes, and AHB error responses are reported as pslverr.

Parameters:
W_PADDR, 16, APB address width (must be < W_HADDR)
W_HADDR, 32, AHB-Lite address width
W_DATA, 32, data width on both sides (32 or 64)
HADDR_BASE, 32'h0000_0000, supplies haddr[W_HADDR-1:W_PADDR]; low W_PADDR bits ignored

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
apbs_psel  in  1  APB select
apbs_penable  in  1  APB enable (access phase)
apbs_pwrite  in  1  APB write
apbs_paddr  in  W_PADDR  APB address
apbs_pwdata  in  W_DATA  APB write data
apbs_pready  out  1  APB ready
apbs_prdata  out  W_DATA  APB read data
apbs_pslverr  out  1  APB error
ahblm_hready  in  1  AHB-Lite ready
ahblm_hresp  in  1  AHB-Lite response (1 = ERROR)
ahblm_haddr  out  W_HADDR  AHB address
ahblm_hwrite  out  1  AHB write
ahblm_htrans  out  2  AHB transfer type
ahblm_hsize  out  3  constant log2(W_DATA/8)
ahblm_hburst  out  3  constant 3'b000 (SINGLE)
ahblm_hprot  out  4  constant 4'b0011 (non-cacheable, privileged data)
ahblm_hmastlock  out  1  constant 0
ahblm_hwdata  out  W_DATA  AHB write data
ahblm_hrdata  in  W_DATA  AHB read data

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: state S_IDLE; haddr, hwrite, hwdata, prdata, pslverr = 0. htrans = IDLE and pready = 0 (both state-decoded).
- State machine:
  - S_IDLE: htrans=IDLE. On psel && !penable (APB setup), register the following and go to S_ADDR:
    - haddr <= {HADDR_BASE[W_HADDR-1:W_PADDR], paddr} with the low log2(W_DATA/8) bits forced 0
    - hwrite <= pwrite
    - hwdata <= pwdata, captured only when pwrite
  - S_ADDR: htrans=NONSEQ. haddr, hwrite and all control are held stable. Stays in S_ADDR while hready=0. On hready=1, go to S_DATA.
  - S_DATA: htrans=IDLE; hwdata held. While hready=0, stay, including the first ERROR cycle (hresp=1, hready=0). On hready=1:
    - pslverr <= hresp
    - prdata <= hrdata if !hwrite, else prdata <= 0
    - go to S_RESP
  - S_RESP: pready=1 for exactly one cycle, then S_IDLE.
- pready = (state==S_RESP), combinational from state only. pready is 0 in all other states, including the APB access-phase cycles while the AHB side is busy.
- Minimum latency: setup at T, access begins T+1, pready high at T+3 when both AHB phases have zero wait states (2 APB wait states). Each AHB wait cycle adds one.
- Back-to-back: an APB setup may arrive the cycle after S_RESP and is accepted from S_IDLE with no bubble.
- Error: the two-cycle AHB ERROR response is absorbed inside S_DATA. prdata on an errored read = sampled hrdata (don't-care value, but deterministic). No retry. The bridge never issues a follow-on transfer, so no cancellation is needed.
- An APB setup seen outside S_IDLE is a protocol violation and is ignored. psel dropping mid-transfer does not abort the AHB transfer: the AHB side completes, and pready still pulses in S_RESP.
- Reset mid-operation: all state returns to reset values immediately. The AHB slave may see an abandoned address or data phase, which is acceptable only under a system-wide reset.
- The AHB outputs never change while in S_ADDR with hready=0. This is required by AHB-Lite.

Decomposition:
- Shared constants file (busfabric AHB-Lite definitions): HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HBURST_SINGLE, HRESP_OKAY/ERROR, HPROT default. The same constants are reused by other AHB blocks.
- State encodings are local constants: S_IDLE, S_ADDR, S_DATA, S_RESP, 2-bit.
- No sub-module. The block is a single FSM plus capture registers.

Test Plan:
- Zero-wait read: APB read paddr=16'h0124, AHB returns hrdata=32'hCAFE_F00D, hready=1 throughout -> haddr=32'h0000_0124, NONSEQ for 1 cycle; pready at T+3; prdata=32'hCAFE_F00D; pslverr=0.
- Write with AHB wait states: pwdata=32'h1234_5678, hready low 2 cycles in address phase and 3 in data phase -> haddr/htrans stable while stalled; hwdata=32'h1234_5678 throughout data phase; pready exactly 1 cycle at T+8.
- Error response: read, data phase gives hresp=1/hready=0 then hresp=1/hready=1 -> pready 1 cycle after, pslverr=1; next transfer has pslverr=0.
- Back-to-back: write then read with setup the cycle after pready -> two NONSEQ transfers, no lost or merged transfers; HADDR_BASE=32'h4000_0000 gives haddr=32'h4000_xxxx.
- Alignment and constants: paddr=16'h0007 -> haddr low bits = 2'b00; hsize=3'b010, hburst=0, hprot=4'b0011, hmastlock=0 always.
- Reset in S_DATA: assert rst_n=0 mid-transfer -> htrans=IDLE and pready=0 immediately; after release, a fresh read completes normally.
